serv_bufreg_ls: RTL

Parametrised load/store/shift data buffer for the bit-serial core, with W bits moved per enabled cycle.
- Serially collects operand B into a 32-bit register.
- Stores: drives the bus with lane-replicated data and byte selects.
- Loads: captures bus data, then lane-extracts, sign/zero-extends and drains it serially to rd.
- Shifts: runs a shift-amount downcounter with a residual step for amounts not divisible by W.
Sits between the decoder/counter and the data bus, replacing the fixed-function buffer register.

---
 rtl/serv_bufreg_ls.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/serv_bufreg_ls.sv
// serv_bufreg_ls -- load/store/shift data buffer for the bit-serial core.
//
// Moves W bits per enabled cycle. Operand B is collected serially into a
// 32-bit register. For memory ops the register then drives a bus request:
// stores present lane-replicated data with byte selects, loads capture bus
// data, extract and extend the addressed lane, and drain it serially on o_q.
// For shifts the collected low five bits become a shift-amount downcounter.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_en                serial step enable
//   i_init              start of operation (honoured in IDLE only)
//   i_cnt_done          last enabled cycle of the current 32-bit phase
//   i_op_b_sel, i_rs2, i_imm, o_op_b   operand B select and result
//   i_mem_op, i_mem_we, i_size, i_signed, i_lsb   memory op attributes
//   i_shift_op          shift operation
//   o_bus_stb, o_bus_we, o_bus_sel, o_bus_dat, i_bus_ack, i_bus_dat   data bus
//   o_q                 serial load result (low W bits of the buffer)
//   o_sh_done, o_sh_done_r, o_shift_residual   shift counter status
//   o_busy              block is not idle
//   o_state             FSM state, for debug and checkers
//
// Bus handshake: o_bus_stb is the request (valid) and i_bus_ack is its
// completion (ready). Once raised, o_bus_stb and o_bus_we/sel/dat stay stable
// until the cycle in which i_bus_ack is sampled high; the request drops on
// that edge. i_bus_ack is ignored whenever no request is outstanding.

module serv_bufreg_ls #(
  parameter  int W  = 1,
  localparam int LB = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_init,
  input  logic          i_cnt_done,
  input  logic          i_op_b_sel,
  input  logic [W-1:0]  i_rs2,
  input  logic [W-1:0]  i_imm,
  output logic [W-1:0]  o_op_b,
  input  logic          i_mem_op,
  input  logic          i_mem_we,
  input  logic [1:0]    i_size,
  input  logic          i_signed,
  input  logic [1:0]    i_lsb,
  input  logic          i_shift_op,
  output logic          o_bus_stb,
  output logic          o_bus_we,
  output logic [3:0]    o_bus_sel,
  output logic [31:0]   o_bus_dat,
  input  logic          i_bus_ack,
  input  logic [31:0]   i_bus_dat,
  output logic [W-1:0]  o_q,
  output logic          o_sh_done,
  output logic          o_sh_done_r,
  output logic [LB:0]   o_shift_residual,
  output logic          o_busy,
  output logic [2:0]    o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_REQ   = 3'd2,
    S_DRAIN = 3'd3,
    S_COUNT = 3'd4
  } state_t;

  localparam logic [5:0] WSTEP = 6'(W);
  // Low shamt bits that do not fit a whole W step; zero mask when W=1.
  localparam logic [4:0] RMASK = 5'(W - 1);

  state_t        state_q;
  logic [31:0]   dat_q;
  logic [5:0]    cnt_q;
  logic          res_pend_q;
  logic          stb_q;
  logic          sh_done_r_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [1:0]    lsb_q;

  logic [31:0]   fill_d;
  logic [31:0]   drain_d;
  logic [31:0]   ld_d;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [5:0]    step;
  logic          sh_done;
  logic [3:0]    bus_sel_d;
  logic [31:0]   bus_dat_d;

  assign o_op_b  = i_op_b_sel ? i_rs2 : i_imm;
  assign fill_d  = {o_op_b, dat_q[31:W]};
  assign drain_d = {{W{1'b0}}, dat_q[31:W]};

  // While counting, the buffer still holds the collected operand, so its low
  // five bits are the shift amount. The first step consumes the residual
  // (shamt mod W) so the remaining count is a whole number of W steps.
  assign step    = res_pend_q ? {1'b0, dat_q[4:0] & RMASK} : WSTEP;
  assign sh_done = (state_q == S_COUNT) && (cnt_q < step);

  assign o_sh_done        = sh_done;
  assign o_sh_done_r      = sh_done_r_q;
  assign o_shift_residual = ((state_q == S_COUNT) && res_pend_q) ? step[LB:0] : '0;

  assign o_q      = dat_q[W-1:0];
  assign o_busy   = (state_q != S_IDLE);
  assign o_state  = state_q;
  assign o_bus_stb = stb_q;
  assign o_bus_we  = stb_q & we_q;
  assign o_bus_sel = bus_sel_d;
  assign o_bus_dat = bus_dat_d;

  // Store data is replicated across lanes so the byte selects alone place it.
  always_comb begin
    bus_sel_d = 4'b1111;
    bus_dat_d = dat_q;
    case (size_q)
      2'd0: begin
        bus_sel_d = 4'b0001 << lsb_q;
        bus_dat_d = {4{dat_q[7:0]}};
      end
      2'd1: begin
        bus_sel_d = lsb_q[1] ? 4'b1100 : 4'b0011;
        bus_dat_d = {2{dat_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (lsb_q)
      2'd0:    ld_byte = i_bus_dat[7:0];
      2'd1:    ld_byte = i_bus_dat[15:8];
      2'd2:    ld_byte = i_bus_dat[23:16];
      default: ld_byte = i_bus_dat[31:24];
    endcase
    ld_half = lsb_q[1] ? i_bus_dat[31:16] : i_bus_dat[15:0];
    case (size_q)
      2'd0:    ld_d = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_d = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_d = i_bus_dat;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      dat_q       <= '0;
      cnt_q       <= '0;
      res_pend_q  <= 1'b0;
      stb_q       <= 1'b0;
      sh_done_r_q <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      lsb_q       <= '0;
    end else begin
      sh_done_r_q <= sh_done;
      case (state_q)
        S_IDLE: begin
          if (i_init && i_en) state_q <= S_FILL;
        end
        S_FILL: begin
          if (i_en) begin
            dat_q <= fill_d;
            if (i_cnt_done) begin
              if (i_mem_op) begin
                we_q     <= i_mem_we;
                size_q   <= i_size;
                signed_q <= i_signed;
                lsb_q    <= i_lsb;
                stb_q    <= 1'b1;
                state_q  <= S_REQ;
              end else if (i_shift_op) begin
                cnt_q      <= {1'b0, fill_d[4:0]};
                res_pend_q <= |(fill_d[4:0] & RMASK);
                state_q    <= S_COUNT;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_REQ: begin
          if (i_bus_ack) begin
            stb_q <= 1'b0;
            if (we_q) begin
              state_q <= S_IDLE;
            end else begin
              dat_q   <= ld_d;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (i_en) begin
            dat_q <= drain_d;
            if (i_cnt_done) state_q <= S_IDLE;
          end
        end
        S_COUNT: begin
          if (i_en) begin
            if (!sh_done) begin
              cnt_q      <= cnt_q - step;
              res_pend_q <= 1'b0;
            end
            if (i_cnt_done) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
